// File: rtl/fp_arb_pkg.sv
// Shared types and constants for the FP_Add sharing arbiter.
package fp_arb_pkg;

  localparam int FP_WIDTH    = 32;
  localparam int DEF_LATENCY = 7;
  // Tag IDs are sized for the largest supported requester count (8).
  localparam int MAX_IDW     = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic               v;
    logic [MAX_IDW-1:0] id;
  } tag_t;

endpackage

// File: rtl/fp_arb_rr_pick.sv
// Combinational requester picker: round-robin starting after ptr_i, or
// lowest-index-wins when FP_ARB_FIXED_PRIO_EN is defined.
module fp_arb_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  id_o,
  output logic            valid_o
);

  always_comb begin
    int idx;
    idx     = 0;
    gnt_o   = '0;
    id_o    = '0;
    valid_o = 1'b0;
`ifdef FP_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) begin
      idx = i;
      if (en_i && req_i[idx] && !valid_o) begin
        valid_o = 1'b1;
        id_o    = IDW'(idx);
      end
    end
`else
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr_i) + k) % NREQ;
      if (en_i && req_i[idx] && !valid_o) begin
        valid_o = 1'b1;
        id_o    = IDW'(idx);
      end
    end
`endif
    if (valid_o) gnt_o[id_o] = 1'b1;
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one pipelined FP adder between NREQ requesters; a tag pipe moving in
// lockstep with the adder routes sums back. FP_ARB_FIXED_PRIO_EN selects fixed priority.
module fp_add_arbiter
  import fp_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int LATENCY = DEF_LATENCY,
  parameter int IDW     = $clog2(NREQ),
  parameter int CNTW    = $clog2(LATENCY + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*FP_WIDTH-1:0] req_a,
  input  logic [NREQ*FP_WIDTH-1:0] req_b,
  output logic [NREQ-1:0]          req_ready,
  output logic [FP_WIDTH-1:0]      add_a,
  output logic [FP_WIDTH-1:0]      add_b,
  output logic                     add_start,
  input  logic [FP_WIDTH-1:0]      add_sum,
  output logic                     res_valid,
  output logic [IDW-1:0]           res_id,
  output logic [FP_WIDTH-1:0]      res_data,
  input  logic                     res_ready,
  input  logic                     flush,
  output logic                     busy,
  output logic [CNTW-1:0]          inflight
);

  state_e          state_q, state_d;
  tag_t            tag_q [LATENCY];
  tag_t            tag_d [LATENCY];
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [CNTW-1:0] inflight_q, inflight_d;

  tag_t            head;
  logic            stall, issue_ok, any_tag, tags_empty_d, res_hs;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            gnt_valid;

  assign head     = tag_q[LATENCY-1];
  assign stall    = head.v & ~res_ready;
  assign issue_ok = ~rst & ~stall & (state_q == RUN) & ~flush;

  fp_arb_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .en_i    (issue_ok),
    .gnt_o   (gnt),
    .id_o    (gnt_id),
    .valid_o (gnt_valid)
  );

  always_comb begin
    add_a = '0;
    add_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        add_a = req_a[FP_WIDTH*i +: FP_WIDTH];
        add_b = req_b[FP_WIDTH*i +: FP_WIDTH];
      end
    end
  end

  always_comb begin
    any_tag = 1'b0;
    for (int i = 0; i < LATENCY; i++) any_tag = any_tag | tag_q[i].v;
  end

  assign req_ready = gnt;
  assign add_start = ~rst & ~stall & (gnt_valid | any_tag);
  assign res_valid = ~rst & head.v;
  assign res_id    = head.id[IDW-1:0];
  assign res_data  = add_sum;
  assign res_hs    = res_valid & res_ready;
  assign busy      = (state_q != IDLE);
  assign inflight  = inflight_q;

  always_comb begin
    tag_d        = tag_q;
    ptr_d        = ptr_q;
    inflight_d   = inflight_q;
    state_d      = state_q;
    tags_empty_d = 1'b1;

    if (add_start) begin
      for (int i = LATENCY - 1; i > 0; i--) tag_d[i] = tag_q[i-1];
      tag_d[0].v  = gnt_valid;
      tag_d[0].id = MAX_IDW'(gnt_id);
    end
    if (gnt_valid) ptr_d = gnt_id;

    if (gnt_valid && !res_hs)      inflight_d = inflight_q + 1'b1;
    else if (!gnt_valid && res_hs) inflight_d = inflight_q - 1'b1;

    for (int i = 0; i < LATENCY; i++) begin
      if (tag_d[i].v) tags_empty_d = 1'b0;
    end

    case (state_q)
      IDLE: if (|req_valid && !flush) state_d = RUN;
      RUN: begin
        if (flush)                           state_d = DRAIN;
        else if (tags_empty_d && !(|req_valid)) state_d = IDLE;
      end
      DRAIN: begin
        // With flush still high the pipe just keeps draining.
        if (!flush) begin
          if (tags_empty_d)     state_d = IDLE;
          else if (|req_valid)  state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= IDW'(NREQ - 1);
      inflight_q <= '0;
      for (int i = 0; i < LATENCY; i++) tag_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      inflight_q <= inflight_d;
      for (int i = 0; i < LATENCY; i++) tag_q[i] <= tag_d[i];
    end
  end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Randomized self-checking bench for fp_add_arbiter with a behavioural adder
// and a queue-based reference model of the arbitration and result return.
module tb_fp_add_arbiter;

  localparam int NREQ    = 4;
  localparam int LATENCY = 7;
  localparam int IDW     = $clog2(NREQ);
  localparam int CNTW    = $clog2(LATENCY + 1);

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ*32-1:0]   req_a = '0;
  logic [NREQ*32-1:0]   req_b = '0;
  logic [NREQ-1:0]      req_ready;
  logic [31:0]          add_a, add_b, add_sum;
  logic                 add_start;
  logic                 res_valid;
  logic [IDW-1:0]       res_id;
  logic [31:0]          res_data;
  logic                 res_ready = 1'b1;
  logic                 flush = 1'b0;
  logic                 busy;
  logic [CNTW-1:0]      inflight;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fp_add_arbiter #(.NREQ(NREQ), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .add_a(add_a), .add_b(add_b), .add_start(add_start),
    .add_sum(add_sum), .res_valid(res_valid), .res_id(res_id), .res_data(res_data),
    .res_ready(res_ready), .flush(flush), .busy(busy), .inflight(inflight)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Float add for positive normal operands (truncating), good enough to tag data.
  function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] hi, lo;
    logic [7:0]  d;
    logic [24:0] mh, ml, s;
    if (x[30:23] >= y[30:23]) begin hi = x; lo = y; end
    else begin hi = y; lo = x; end
    d  = hi[30:23] - lo[30:23];
    mh = {2'b01, hi[22:0]};
    ml = (d > 8'd24) ? 25'd0 : ({2'b01, lo[22:0]} >> d);
    s  = mh + ml;
    if (s[24]) return {1'b0, hi[30:23] + 8'd1, s[23:1]};
    return {1'b0, hi[30:23], s[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0] e;
    e = 8'($urandom_range(110, 140));
    return {1'b0, e, 23'($urandom)};
  endfunction

  // Behavioural FP_Add: LATENCY-stage pipe advancing only on add_start.
  logic [31:0] pipe [LATENCY];
  initial for (int i = 0; i < LATENCY; i++) pipe[i] = '0;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
    end else if (add_start) begin
      pipe[0] <= fadd(add_a, add_b);
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign add_sum = pipe[LATENCY-1];

  // Reference model: outstanding results in issue order, each with the
  // number of adder advances it has seen.
  typedef struct { int id; logic [31:0] data; int age; } ent_t;
  ent_t q[$];
  int   m_state = 0;          // 0 idle, 1 run, 2 drain
  int   m_last  = NREQ - 1;

  function automatic int pick(input logic [NREQ-1:0] r, input int last, input bit en);
    int j;
    if (!en) return -1;
`ifdef FP_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (r[i]) return i;
`else
    for (int k = 1; k <= NREQ; k++) begin
      j = (last + k) % NREQ;
      if (r[j]) return j;
    end
`endif
    return -1;
  endfunction

  always @(negedge clk) begin
    bit          head_v, stall_m, issue_m, exp_start, empty, anyreq;
    int          e_id;
    logic [31:0] exp_a, exp_b;
    logic [NREQ-1:0] exp_rdy;
    if (rst) begin
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_add_start", 32'(add_start), 32'd0);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      q.delete();
      m_state = 0;
      m_last  = NREQ - 1;
    end else begin
      head_v  = (q.size() != 0) && (q[0].age == LATENCY);
      stall_m = head_v && !res_ready;
      issue_m = !stall_m && (m_state == 1) && !flush;
      e_id    = pick(req_valid, m_last, issue_m);
      exp_rdy = '0;
      exp_a   = '0;
      exp_b   = '0;
      if (e_id >= 0) begin
        exp_rdy[e_id] = 1'b1;
        exp_a = req_a[e_id*32 +: 32];
        exp_b = req_b[e_id*32 +: 32];
      end
      exp_start = !stall_m && ((e_id >= 0) || (q.size() != 0));

      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      check("add_a", add_a, exp_a);
      check("add_b", add_b, exp_b);
      check("add_start", 32'(add_start), 32'(exp_start));
      check("res_valid", 32'(res_valid), 32'(head_v));
      check("inflight", 32'(inflight), 32'(q.size()));
      check("busy", 32'(busy), 32'(m_state != 0));
      if (head_v) begin
        check("res_id", 32'(res_id), 32'(q[0].id));
        check("res_data", res_data, q[0].data);
      end

      if (exp_start) begin
        if (head_v && res_ready) void'(q.pop_front());
        foreach (q[k]) q[k].age++;
        if (e_id >= 0) begin
          q.push_back('{e_id, fadd(exp_a, exp_b), 1});
          m_last = e_id;
        end
      end
      empty  = (q.size() == 0);
      anyreq = |req_valid;
      case (m_state)
        0: if (anyreq && !flush) m_state = 1;
        1: if (flush) m_state = 2; else if (empty && !anyreq) m_state = 0;
        default: if (!flush) begin
          if (empty) m_state = 0;
          else if (anyreq) m_state = 1;
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_operands();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*32 +: 32] = rand_fp();
      req_b[i*32 +: 32] = rand_fp();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(input int limit);
    req_valid = '0;
    flush     = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (q.size() == 0 && m_state == 0) break;
    end
    check("drain_done", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int gcycle, rcycle, ngnt, max_if, nstall, ngrant_fl, nstale, g1, g2;
    bit found;
    int order [8];
    logic [31:0] held_data;
    logic [IDW-1:0] held_id;

    do_reset();

    // single transaction from requester 0
    req_a[31:0] = 32'h3F800000;
    req_b[31:0] = 32'h40000000;
    req_valid   = 4'b0001;
    found = 0; gcycle = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (req_ready[0]) begin found = 1; gcycle = c; end
    end
    check("single_granted", 32'(found), 32'd1);
    tick();
    req_valid = '0;
    found = 0; rcycle = 0;
    for (int c = gcycle + 1; c < gcycle + 20 && !found; c++) begin
      @(negedge clk);
      if (res_valid) begin found = 1; rcycle = c; end
    end
    check("single_result", 32'(found), 32'd1);
    check("single_latency", 32'(rcycle - gcycle), 32'(LATENCY));
    check("single_data", res_data, 32'h40400000);
    check("single_id", 32'(res_id), 32'd0);
    drain(20);

    // all four requesting: round-robin order and inflight saturation
    do_reset();
    rand_operands();
    req_valid = '1;
    ngnt = 0; max_if = 0;
    for (int c = 0; c < 40 && ngnt < 8; c++) begin
      @(negedge clk);
      if (int'(inflight) > max_if) max_if = int'(inflight);
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) begin order[ngnt] = i; ngnt++; end
      @(posedge clk); #1;
      if (ngnt >= 8) req_valid = '0;
    end
    check("rr_issue_count", 32'(ngnt), 32'd8);
    for (int k = 0; k < 8; k++) check("rr_order", 32'(order[k]), 32'(k % NREQ));
    @(negedge clk);
    if (int'(inflight) > max_if) max_if = int'(inflight);
    check("inflight_max", 32'(max_if), 32'(LATENCY));
    drain(30);

    // back-pressure for 5 cycles while a result is presented
    rand_operands();
    req_valid = '1;
    found = 0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (res_valid) found = 1;
    end
    check("bp_result_seen", 32'(found), 32'd1);
    tick();
    res_ready = 1'b0;
    nstall = 0;
    @(negedge clk);
    held_data = res_data;
    held_id   = res_id;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      if (!add_start && req_ready == '0 && res_valid) nstall++;
      check("bp_data_hold", res_data, held_data);
      check("bp_id_hold", 32'(res_id), 32'(held_id));
    end
    check("bp_stall_cycles", 32'(nstall), 32'd5);
    tick();
    res_ready = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    drain(30);

    // flush with three in flight and all requesters still asking
    rand_operands();
    req_valid = '1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (q.size() >= 3) break;
    end
    check("flush_setup", 32'(q.size()), 32'd3);
    flush = 1'b1;
    ngrant_fl = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (req_ready != '0) ngrant_fl++;
    end
    check("flush_no_grant", 32'(ngrant_fl), 32'd0);
    check("flush_drained", 32'(inflight), 32'd0);
    check("flush_busy_held", 32'(busy), 32'd1);
    tick();
    flush = 1'b0;
    req_valid = '0;
    tick();
    tick();
    check("flush_idle", 32'(busy), 32'd0);

    // reset mid-operation
    rand_operands();
    req_valid = '1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (q.size() >= 4) break;
    end
    check("rst_setup", 32'(inflight), 32'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = '0;
    nstale = 0;
    @(negedge clk);
    check("rst_inflight", 32'(inflight), 32'd0);
    for (int c = 0; c < 10; c++) begin
      if (res_valid) nstale++;
      @(negedge clk);
    end
    check("rst_no_stale", 32'(nstale), 32'd0);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      tick();
      rand_operands();
      req_valid = NREQ'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
    end
    drain(40);

`ifdef FP_ARB_FIXED_PRIO_EN
    do_reset();
    rand_operands();
    req_valid = 4'b0110;
    g1 = 0; g2 = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (req_ready[1]) g1++;
      if (req_ready[2]) g2++;
    end
    check("fixed_r1_granted", 32'(g1 > 0), 32'd1);
    check("fixed_r2_never", 32'(g2), 32'd0);
    drain(30);
`else
    g1 = 0; g2 = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
